fl_netcope_arbiter: RTL and testbench
=====================================

# fl_netcope_arbiter

Frame-granular round-robin arbiter that shares one NetCOPE header adder between INPUTS FrameLink sources. It selects one input at a time, passes that input's whole frame to the adder input, and reports the source index on TX_IFC for the adder to write into the NetCOPE header. It sits directly upstream of the netcope adder in the FL edit chain.

## Interface
- DATA_WIDTH, 64, FL data width in bits; 8..128, multiple of 8
- INPUTS, 4, number of FL sources; power of two, 2..16
- Derived: REMW = log2(DATA_WIDTH/8); IFCW = log2(INPUTS)

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- EN  in  INPUTS  per-input enable; 0 makes the input ineligible for new grants
- RX_DATA  in  INPUTS*DATA_WIDTH  packed input data; input i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- RX_REM  in  INPUTS*REMW  packed byte remainder
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  INPUTS each  FL framing, active-low
- RX_SRC_RDY_N  in  INPUTS  source ready, active-low
- RX_DST_RDY_N  out  INPUTS  destination ready back to each source, active-low
- TX_DATA  out  DATA_WIDTH  output data
- TX_REM  out  REMW  output remainder
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  output framing
- TX_SRC_RDY_N  out  1  output source ready
- TX_DST_RDY_N  in  1  output destination ready from the adder
- TX_IFC  out  IFCW  index of the granted input; stable for the whole frame
- BUSY  out  1  1 while in LOCKED

## Operation
- FSM states: IDLE and LOCKED. Registers: state, grant (IFCW bits), pointer (IFCW bits).
- Request: input i requests when EN[i]=1, RX_SRC_RDY_N[i]=0 and RX_SOF_N[i]=0. Only a frame start is eligible. A source showing SRC_RDY without SOF in IDLE is ignored and stalls.
- IDLE: if any request exists, grant <= first requesting index searching pointer, pointer+1, … (mod INPUTS), and state <= LOCKED. With no request, the FSM stays in IDLE.
- In IDLE, all RX_DST_RDY_N=1, TX_SRC_RDY_N=1 and TX_SOF_N/EOF_N/SOP_N/EOP_N=1. TX_DATA and TX_REM are don't-care.
- LOCKED: the TX fields are a combinational mux of input grant.
  - TX_SRC_RDY_N = RX_SRC_RDY_N[grant]
  - RX_DST_RDY_N[grant] = TX_DST_RDY_N
  - all other RX_DST_RDY_N = 1
  - TX_IFC = grant
- A transfer is a beat with TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
- A transfer with TX_EOF_N=0 sets state <= IDLE and pointer <= grant+1 (mod INPUTS, natural wrap of IFCW bits).
- EN is sampled only at grant. Deasserting EN[grant] mid-frame does not abort the frame.
- The arbiter does not check protocol beyond SOF/EOF. A SOF seen while LOCKED is passed through unchanged.

## Timing
- Reset values (asynchronous, while RESET_N=0): state=IDLE, grant=0, pointer=0, TX_IFC=0, BUSY=0, TX_SRC_RDY_N=1, all TX framing=1, all RX_DST_RDY_N=1.
- Arbitration latency is 1 cycle: a request first visible at edge k is granted at edge k, and its SOF beat can transfer in cycle k+1.
- LOCKED datapath latency is 0 (pure mux). Backpressure propagates combinationally.
- Every frame boundary costs one IDLE bubble: the EOF transfer happens at edge k, and the next grant cannot occur before edge k+1.
- A single-beat frame (SOF=EOF=0 on the same beat) occupies LOCKED for exactly that one transfer.
- TX_DST_RDY_N=1 holds the current beat. The FSM and pointer do not change, and all other inputs stay blocked.
- RESET_N asserted mid-frame forces IDLE immediately. The partial frame is abandoned and nothing is replayed. After release, arbitration restarts from pointer=0.
- TX_IFC and BUSY are registered (driven from grant/state). TX_IFC holds its last value in IDLE.

## Test plan
- Reset: hold RESET_N=0 with all inputs requesting -> TX_SRC_RDY_N=1, all RX_DST_RDY_N=1, TX_IFC=0, BUSY=0, with no clock edge required.
- Single source: input 2 sends a 3-beat frame, TX_DST_RDY_N=0 -> SOF appears on TX one cycle after the request, TX_IFC=2, 3 beats pass unchanged, then pointer=3.
- Fairness: all 4 inputs request continuously with 2-beat frames -> grant order 0,1,2,3,0,1; one IDLE cycle between frames; TX_IFC matches each frame.
- Backpressure: TX_DST_RDY_N=1 for 5 cycles mid-frame on input 1 -> TX beat held, RX_DST_RDY_N[1]=1, other inputs blocked, frame completes intact afterwards.
- Enable: EN[0] cleared during input 0's frame, inputs 0 and 1 requesting -> input 0's frame finishes, next grant is 1, and input 0 is never granted again until EN[0]=1.
- Mid-frame reset and wrap: RESET_N pulsed low during input 3's frame -> immediate IDLE, pointer=0; a subsequent frame on input 3 alone is granted, and after its EOF pointer wraps to 0.

Source files
------------

// File: rtl/fl_netcope_arbiter_if.sv
// rtl/fl_netcope_arbiter_if.sv - FrameLink source/sink bundle shared by the netcope arbiter and its environment
interface fl_netcope_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int INPUTS     = 4
);
   localparam int REMW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
   localparam int IFCW = $clog2(INPUTS);

   logic [INPUTS-1:0]            en;
   logic [INPUTS*DATA_WIDTH-1:0] rx_data;
   logic [INPUTS*REMW-1:0]       rx_rem;
   logic [INPUTS-1:0]            rx_sof_n;
   logic [INPUTS-1:0]            rx_eof_n;
   logic [INPUTS-1:0]            rx_sop_n;
   logic [INPUTS-1:0]            rx_eop_n;
   logic [INPUTS-1:0]            rx_src_rdy_n;
   logic [INPUTS-1:0]            rx_dst_rdy_n;
   logic [DATA_WIDTH-1:0]        tx_data;
   logic [REMW-1:0]              tx_rem;
   logic                         tx_sof_n;
   logic                         tx_eof_n;
   logic                         tx_sop_n;
   logic                         tx_eop_n;
   logic                         tx_src_rdy_n;
   logic                         tx_dst_rdy_n;
   logic [IFCW-1:0]              tx_ifc;
   logic                         busy;

   // arbiter view: consumes the sources and the adder's ready, drives everything else
   modport slave (
      input  en, rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n,
      input  tx_dst_rdy_n,
      output rx_dst_rdy_n,
      output tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n,
      output tx_ifc, busy
   );

   // environment view: the FL sources plus the downstream adder
   modport master (
      output en, rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n,
      output tx_dst_rdy_n,
      input  rx_dst_rdy_n,
      input  tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n,
      input  tx_ifc, busy
   );
endinterface

// File: rtl/fl_netcope_arbiter.sv
// rtl/fl_netcope_arbiter.sv - frame-granular round-robin arbiter feeding one netcope header adder
module fl_netcope_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int INPUTS     = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   fl_netcope_arbiter_if.slave fl
);
   localparam int REMW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
   localparam int IFCW = $clog2(INPUTS);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]        state;
   logic [IFCW-1:0]   grant;
   logic [IFCW-1:0]   pointer;
   logic [INPUTS-1:0] req;
   logic              req_any;
   logic [IFCW-1:0]   req_idx;
   logic [IFCW-1:0]   cand;
   logic [INPUTS-1:0] dst_rdy_n;
   logic              locked;
   logic              src_rdy_n;
   logic              eof_n;
   logic              transfer;

   // only an enabled, ready frame start may win a grant
   assign req    = fl.en & ~fl.rx_src_rdy_n & ~fl.rx_sof_n;
   assign locked = (state == S_LOCKED);

   // first requester scanning pointer, pointer+1, ... with natural index wrap
   always_comb begin
      req_any = 1'b0;
      req_idx = pointer;
      cand    = pointer;
      for (int off = 0; off < INPUTS; off++) begin
         cand = pointer + IFCW'(off);
         if (!req_any && req[cand]) begin
            req_any = 1'b1;
            req_idx = cand;
         end
      end
   end

   // only the granted source sees the adder's ready; everyone else stalls
   always_comb begin
      dst_rdy_n = '1;
      if (locked) dst_rdy_n[grant] = fl.tx_dst_rdy_n;
   end

   assign src_rdy_n = locked ? fl.rx_src_rdy_n[grant] : 1'b1;
   assign eof_n     = locked ? fl.rx_eof_n[grant]     : 1'b1;
   assign transfer  = ~src_rdy_n & ~fl.tx_dst_rdy_n;

   assign fl.rx_dst_rdy_n = dst_rdy_n;
   assign fl.tx_data      = fl.rx_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign fl.tx_rem       = fl.rx_rem[int'(grant)*REMW +: REMW];
   assign fl.tx_sof_n     = locked ? fl.rx_sof_n[grant] : 1'b1;
   assign fl.tx_eof_n     = eof_n;
   assign fl.tx_sop_n     = locked ? fl.rx_sop_n[grant] : 1'b1;
   assign fl.tx_eop_n     = locked ? fl.rx_eop_n[grant] : 1'b1;
   assign fl.tx_src_rdy_n = src_rdy_n;
   assign fl.tx_ifc       = grant;
   assign fl.busy         = locked;

   // grant on a frame start, release after the EOF beat has been accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         grant   <= '0;
         pointer <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_any) begin
                  grant <= req_idx;
                  state <= S_LOCKED;
               end
            end
            default: begin
               if (transfer && !eof_n) begin
                  state   <= S_IDLE;
                  pointer <= grant + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fl_netcope_arbiter.sv
// tb/tb_fl_netcope_arbiter.sv - directed self-checking bench for fl_netcope_arbiter
module tb_fl_netcope_arbiter;
   localparam int DW = 64;
   localparam int N  = 4;
   localparam int RW = 3;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errors;

   int   beat[N];
   int   len[N];
   bit   active[N];
   bit   cont[N];

   fl_netcope_arbiter_if #(.DATA_WIDTH(DW), .INPUTS(N)) fl ();

   fl_netcope_arbiter #(.DATA_WIDTH(DW), .INPUTS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fl    (fl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(int s, int b);
      logic [31:0] hi;
      logic [31:0] lo;
      hi = 32'hA5A5_0000 + 32'(s);
      lo = 32'h0000_0100 + 32'(b);
      return {hi, lo};
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         fl.rx_src_rdy_n[i]        = !active[i];
         fl.rx_sof_n[i]            = !(active[i] && beat[i] == 0);
         fl.rx_eof_n[i]            = !(active[i] && beat[i] == len[i] - 1);
         fl.rx_sop_n[i]            = fl.rx_sof_n[i];
         fl.rx_eop_n[i]            = fl.rx_eof_n[i];
         fl.rx_data[i*DW +: DW]    = pat(i, beat[i]);
         fl.rx_rem[i*RW +: RW]     = RW'(i + beat[i]);
      end
      #1;
   endtask

   task automatic cycle();
      logic [N-1:0] acc;
      for (int i = 0; i < N; i++) acc[i] = active[i] && !fl.rx_dst_rdy_n[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            beat[i]++;
            if (beat[i] == len[i]) begin
               beat[i] = 0;
               if (!cont[i]) active[i] = 1'b0;
            end
         end
      end
      drive();
   endtask

   task automatic set_src(int i, bit act, int l, bit c);
      active[i] = act;
      len[i]    = l;
      cont[i]   = c;
      beat[i]   = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      fl.en = '1;
      fl.tx_dst_rdy_n = 1'b0;
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 2, 1'b0);
      drive();
      rst_n = 1'b0;
      #1;
      vectors++; if (fl.tx_src_rdy_n !== 1'b1) begin errors++; $display("FAIL reset_src_rdy got %b want 1", fl.tx_src_rdy_n); end
      vectors++; if (fl.rx_dst_rdy_n !== 4'hF) begin errors++; $display("FAIL reset_dst_rdy got %h want f", fl.rx_dst_rdy_n); end
      vectors++; if (fl.tx_ifc !== 2'd0) begin errors++; $display("FAIL reset_ifc got %0d want 0", fl.tx_ifc); end
      vectors++; if (fl.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", fl.busy); end
      vectors++; if ({fl.tx_sof_n, fl.tx_eof_n, fl.tx_sop_n, fl.tx_eop_n} !== 4'hF) begin errors++; $display("FAIL reset_framing got %b want 1111", {fl.tx_sof_n, fl.tx_eof_n, fl.tx_sop_n, fl.tx_eop_n}); end
      cycle();
      vectors++; if (fl.busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b want 0", fl.busy); end
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 1, 1'b0);
      drive();
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_single();
      set_src(2, 1'b1, 3, 1'b0);
      drive();
      vectors++; if (fl.busy !== 1'b0 || fl.tx_src_rdy_n !== 1'b1) begin errors++; $display("FAIL single_pre busy=%b src_rdy_n=%b want 0/1", fl.busy, fl.tx_src_rdy_n); end
      cycle();
      for (int b = 0; b < 3; b++) begin
         vectors++; if (fl.tx_ifc !== 2'd2) begin errors++; $display("FAIL single_ifc beat %0d got %0d want 2", b, fl.tx_ifc); end
         vectors++; if (fl.tx_data !== pat(2, b)) begin errors++; $display("FAIL single_data beat %0d got %h want %h", b, fl.tx_data, pat(2, b)); end
         vectors++; if (fl.tx_rem !== RW'(2 + b)) begin errors++; $display("FAIL single_rem beat %0d got %0d want %0d", b, fl.tx_rem, 2 + b); end
         vectors++; if (fl.tx_sof_n !== (b != 0) || fl.tx_eof_n !== (b != 2)) begin errors++; $display("FAIL single_framing beat %0d got sof_n=%b eof_n=%b want %b/%b", b, fl.tx_sof_n, fl.tx_eof_n, b != 0, b != 2); end
         vectors++; if (fl.rx_dst_rdy_n !== 4'b1011) begin errors++; $display("FAIL single_dst_rdy beat %0d got %b want 1011", b, fl.rx_dst_rdy_n); end
         cycle();
      end
      vectors++; if (fl.busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %b want 0", fl.busy); end
      vectors++; if (dut.pointer !== 2'd3) begin errors++; $display("FAIL single_pointer got %0d want 3", dut.pointer); end
      vectors++; if (fl.tx_ifc !== 2'd2) begin errors++; $display("FAIL single_ifc_hold got %0d want 2", fl.tx_ifc); end
   endtask

   task automatic test_fairness();
      int order[6];
      order = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0;
      #1;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 2, 1'b1);
      drive();
      for (int f = 0; f < 6; f++) begin
         cycle();
         vectors++; if (fl.tx_ifc !== 2'(order[f]) || fl.tx_sof_n !== 1'b0) begin errors++; $display("FAIL fair_grant frame %0d got ifc=%0d sof_n=%b want %0d/0", f, fl.tx_ifc, fl.tx_sof_n, order[f]); end
         vectors++; if (fl.tx_data !== pat(order[f], 0)) begin errors++; $display("FAIL fair_data0 frame %0d got %h want %h", f, fl.tx_data, pat(order[f], 0)); end
         cycle();
         vectors++; if (fl.tx_eof_n !== 1'b0 || fl.tx_data !== pat(order[f], 1)) begin errors++; $display("FAIL fair_data1 frame %0d got eof_n=%b data=%h want 0/%h", f, fl.tx_eof_n, fl.tx_data, pat(order[f], 1)); end
         cycle();
         vectors++; if (fl.busy !== 1'b0 || fl.tx_src_rdy_n !== 1'b1) begin errors++; $display("FAIL fair_bubble frame %0d got busy=%b src_rdy_n=%b want 0/1", f, fl.busy, fl.tx_src_rdy_n); end
      end
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 1, 1'b0);
      drive();
   endtask

   task automatic test_back_to_back();
      set_src(1, 1'b1, 4, 1'b0);
      drive();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd1) begin errors++; $display("FAIL bp_grant got %0d want 1", fl.tx_ifc); end
      cycle();
      fl.tx_dst_rdy_n = 1'b1;
      set_src(3, 1'b1, 1, 1'b0);
      drive();
      for (int c = 0; c < 5; c++) begin
         vectors++; if (fl.tx_data !== pat(1, 1) || fl.tx_src_rdy_n !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got data=%h src_rdy_n=%b want %h/0", c, fl.tx_data, fl.tx_src_rdy_n, pat(1, 1)); end
         vectors++; if (fl.rx_dst_rdy_n !== 4'hF || fl.busy !== 1'b1) begin errors++; $display("FAIL bp_block cycle %0d got dst=%b busy=%b want 1111/1", c, fl.rx_dst_rdy_n, fl.busy); end
         cycle();
      end
      fl.tx_dst_rdy_n = 1'b0;
      drive();
      for (int b = 1; b < 4; b++) begin
         vectors++; if (fl.tx_data !== pat(1, b) || fl.tx_eof_n !== (b != 3) || fl.tx_ifc !== 2'd1) begin errors++; $display("FAIL bp_resume beat %0d got data=%h eof_n=%b ifc=%0d want %h/%b/1", b, fl.tx_data, fl.tx_eof_n, fl.tx_ifc, pat(1, b), b != 3); end
         cycle();
      end
      vectors++; if (fl.busy !== 1'b0) begin errors++; $display("FAIL bp_bubble busy got %b want 0", fl.busy); end
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd3 || fl.tx_sof_n !== 1'b0 || fl.tx_eof_n !== 1'b0) begin errors++; $display("FAIL single_beat got ifc=%0d sof_n=%b eof_n=%b want 3/0/0", fl.tx_ifc, fl.tx_sof_n, fl.tx_eof_n); end
      cycle();
      vectors++; if (fl.busy !== 1'b0 || dut.pointer !== 2'd0) begin errors++; $display("FAIL single_beat_end got busy=%b pointer=%0d want 0/0", fl.busy, dut.pointer); end
   endtask

   task automatic test_enable();
      set_src(0, 1'b1, 3, 1'b1);
      set_src(1, 1'b1, 2, 1'b1);
      drive();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd0 || fl.busy !== 1'b1) begin errors++; $display("FAIL en_first got ifc=%0d busy=%b want 0/1", fl.tx_ifc, fl.busy); end
      fl.en[0] = 1'b0;
      drive();
      cycle();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd0 || fl.tx_eof_n !== 1'b0 || fl.tx_data !== pat(0, 2)) begin errors++; $display("FAIL en_finish got ifc=%0d eof_n=%b data=%h want 0/0/%h", fl.tx_ifc, fl.tx_eof_n, fl.tx_data, pat(0, 2)); end
      cycle();
      for (int f = 0; f < 3; f++) begin
         cycle();
         vectors++; if (fl.tx_ifc !== 2'd1 || fl.rx_dst_rdy_n[0] !== 1'b1) begin errors++; $display("FAIL en_excluded frame %0d got ifc=%0d dst0=%b want 1/1", f, fl.tx_ifc, fl.rx_dst_rdy_n[0]); end
         cycle();
         cycle();
      end
      fl.en[0] = 1'b1;
      drive();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd0) begin errors++; $display("FAIL en_restored got %0d want 0", fl.tx_ifc); end
      for (int b = 0; b < 3; b++) cycle();
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 1, 1'b0);
      drive();
   endtask

   task automatic test_reset_wrap();
      set_src(3, 1'b1, 4, 1'b0);
      drive();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd3) begin errors++; $display("FAIL mid_grant got %0d want 3", fl.tx_ifc); end
      cycle();
      rst_n = 1'b0;
      #1;
      vectors++; if (fl.busy !== 1'b0 || fl.tx_src_rdy_n !== 1'b1 || fl.rx_dst_rdy_n !== 4'hF) begin errors++; $display("FAIL mid_reset got busy=%b src_rdy_n=%b dst=%b want 0/1/1111", fl.busy, fl.tx_src_rdy_n, fl.rx_dst_rdy_n); end
      vectors++; if (fl.tx_ifc !== 2'd0 || dut.pointer !== 2'd0) begin errors++; $display("FAIL mid_reset_regs got ifc=%0d pointer=%0d want 0/0", fl.tx_ifc, dut.pointer); end
      set_src(3, 1'b1, 2, 1'b0);
      cycle();
      rst_n = 1'b1;
      drive();
      cycle();
      vectors++; if (fl.tx_ifc !== 2'd3 || fl.tx_sof_n !== 1'b0 || fl.tx_data !== pat(3, 0)) begin errors++; $display("FAIL wrap_grant got ifc=%0d sof_n=%b data=%h want 3/0/%h", fl.tx_ifc, fl.tx_sof_n, fl.tx_data, pat(3, 0)); end
      cycle();
      cycle();
      vectors++; if (dut.pointer !== 2'd0 || fl.busy !== 1'b0 || fl.tx_ifc !== 2'd3) begin errors++; $display("FAIL wrap_pointer got pointer=%0d busy=%b ifc=%0d want 0/0/3", dut.pointer, fl.busy, fl.tx_ifc); end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_single();
      test_fairness();
      test_back_to_back();
      test_enable();
      test_reset_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
